// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared decode types: immediate formats, opcodes, buffered entry
package decode_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        logic [31:0] imm;
        imm_fmt_e    fmt;
        logic        illegal;
    } dec_entry_t;

endpackage

// File: rtl/decode_skid_buffer.sv
// rtl/decode_skid_buffer.sv - two-entry valid/ready skid buffer for decoded entries
module decode_skid_buffer
    import decode_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  dec_entry_t in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output dec_entry_t out_data
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0] state;
    logic [1:0] next_state;
    dec_entry_t main_q;
    dec_entry_t skid_q;
    logic       in_fire;
    logic       out_fire;

    assign in_fire   = in_valid & in_ready;
    assign out_valid = (state != ST_EMPTY);
    assign out_fire  = out_valid & out_ready;
    assign out_data  = main_q;

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (in_fire) next_state = ST_ONE;
                ST_ONE: begin
                    if (in_fire && !out_fire)      next_state = ST_TWO;
                    else if (!in_fire && out_fire) next_state = ST_EMPTY;
                end
                ST_TWO:   if (out_fire) next_state = ST_ONE;
                default:  next_state = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            state    <= next_state;
            // Registered ready: it already reflects the state we are moving into.
            in_ready <= (next_state != ST_TWO);
            // Flush discards any handshake seen in the same cycle.
            if (!flush) begin
                case (state)
                    ST_EMPTY: if (in_fire) main_q <= in_data;
                    ST_ONE: begin
                        if (in_fire && out_fire) main_q <= in_data;
                        else if (in_fire)        skid_q <= in_data;
                    end
                    ST_TWO:   if (out_fire) main_q <= skid_q;
                    default:  ;
                endcase
            end
        end
    end

endmodule

// File: rtl/immediate_decode_sequencer.sv
// rtl/immediate_decode_sequencer.sv - immediate-format decode front end with skid buffering
module immediate_decode_sequencer
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instruction,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instruction,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_fmt,
    output logic            out_illegal,
    output logic [15:0]     stall_count
);

    logic [6:0]  opcode;
    imm_fmt_e    fmt;
    logic        illegal;
    logic [31:0] imm;
    logic [31:0] ins;
    dec_entry_t  in_entry;
    dec_entry_t  head;

    assign ins    = in_instruction;
    assign opcode = ins[6:0];

    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: fmt = FMT_I;
            OPC_STORE:            fmt = FMT_S;
            OPC_BRANCH:           fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:   fmt = FMT_U;
            OPC_JAL:              fmt = FMT_J;
            OPC_OP:               fmt = FMT_NONE;
            default:              illegal = 1'b1;
        endcase
        // Compressed-encoding space is never accepted here.
        if (ins[1:0] != 2'b11) illegal = 1'b1;
    end

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   imm = {ins[31:12], 12'b0};
            FMT_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    always_comb begin
        in_entry             = '0;
        in_entry.instruction = in_instruction;
        in_entry.pc          = in_pc;
        in_entry.imm         = imm;
        in_entry.fmt         = fmt;
        in_entry.illegal     = illegal;
    end

    decode_skid_buffer u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign out_instruction = head.instruction;
    assign out_pc          = head.pc;
    assign out_imm         = head.imm;
    assign out_imm_fmt     = head.fmt;
    assign out_illegal     = head.illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_immediate_decode_sequencer.sv
// tb/tb_immediate_decode_sequencer.sv - directed self-checking bench for immediate_decode_sequencer
module tb_immediate_decode_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [2:0]  out_imm_fmt;
    logic        out_illegal;
    logic [15:0] stall_count;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    immediate_decode_sequencer #(.XLEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instruction  (in_instruction),
        .in_pc           (in_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .out_imm         (out_imm),
        .out_imm_fmt     (out_imm_fmt),
        .out_illegal     (out_illegal),
        .stall_count     (stall_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_decode(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                                input logic [31:0] imm, input logic [2:0] fmt, input logic ill);
        in_valid = 1'b1;
        in_instruction = ins;
        in_pc = pc;
        tick();
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_instr"}, 64'(out_instruction), 64'(ins));
        check({tag, "_pc"}, 64'(out_pc), 64'(pc));
        check({tag, "_imm"}, 64'(out_imm), 64'(imm));
        check({tag, "_fmt"}, 64'(out_imm_fmt), 64'(fmt));
        check({tag, "_illegal"}, 64'(out_illegal), 64'(ill));
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_instruction = '0;
        in_pc = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_instr", 64'(out_instruction), 64'd0);
        check("rst_pc", 64'(out_pc), 64'd0);
        check("rst_imm", 64'(out_imm), 64'd0);
        check("rst_fmt", 64'(out_imm_fmt), 64'd0);
        check("rst_illegal", 64'(out_illegal), 64'd0);
        check("rst_stall", 64'(stall_count), 64'd0);

        // Back-to-back decode with out_ready high: one result per cycle.
        check_decode("dec_i", 32'hFFF00093, 32'h1000, 32'hFFFFFFFF, 3'd1, 1'b0);
        check_decode("dec_s", 32'hFE112E23, 32'h1004, 32'hFFFFFFFC, 3'd2, 1'b0);
        check_decode("dec_b", 32'h00000863, 32'h1008, 32'h00000010, 3'd3, 1'b0);
        check_decode("dec_u", 32'h123452B7, 32'h100C, 32'h12345000, 3'd4, 1'b0);
        check_decode("dec_j", 32'hFF9FF06F, 32'h1010, 32'hFFFFFFF8, 3'd5, 1'b0);
        check_decode("dec_zero", 32'h00000000, 32'h1014, 32'h00000000, 3'd0, 1'b1);
        check_decode("dec_add", 32'h002081B3, 32'h1018, 32'h00000000, 3'd0, 1'b0);
        in_valid = 1'b0;
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_stall", 64'(stall_count), 64'd0);

        // Backpressure: third instruction must be refused.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instruction = 32'h00000013;
        in_pc = 32'h0;
        tick();
        check("bp_first_valid", 64'(out_valid), 64'd1);
        check("bp_first_ready", 64'(in_ready), 64'd1);
        in_pc = 32'h4;
        tick();
        check("bp_two_ready", 64'(in_ready), 64'd0);
        check("bp_two_pc", 64'(out_pc), 64'h0);
        check("bp_stall1", 64'(stall_count), 64'd1);
        in_pc = 32'h8;
        tick();
        check("bp_hold_ready", 64'(in_ready), 64'd0);
        check("bp_hold_pc", 64'(out_pc), 64'h0);
        check("bp_stall2", 64'(stall_count), 64'd2);
        tick();
        check("bp_stall3", 64'(stall_count), 64'd3);
        out_ready = 1'b1;
        #1;
        check("bp_out0", 64'(out_pc), 64'h0);
        tick();
        check("bp_out4", 64'(out_pc), 64'h4);
        check("bp_out4_valid", 64'(out_valid), 64'd1);
        check("bp_ready_back", 64'(in_ready), 64'd1);
        tick();
        check("bp_out8", 64'(out_pc), 64'h8);
        check("bp_out8_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        tick();
        check("bp_empty", 64'(out_valid), 64'd0);
        check("bp_stall_final", 64'(stall_count), 64'd3);

        // Flush while full, with a competing input handshake.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_pc = 32'h100;
        tick();
        in_pc = 32'h104;
        tick();
        check("fl_full_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        in_pc = 32'h108;
        in_instruction = 32'h00100093;
        tick();
        flush = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready), 64'd1);
        check("fl_stall", 64'(stall_count), 64'd5);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("fl_no_ghost", 64'(out_valid), 64'd0);
        in_valid = 1'b1;
        in_pc = 32'h10C;
        tick();
        check("fl_next_pc", 64'(out_pc), 64'h10C);
        in_valid = 1'b0;
        tick();

        // Reset while full with input still offered.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_pc = 32'h200;
        in_instruction = 32'hFFF00093;
        tick();
        in_pc = 32'h204;
        tick();
        check("rs_pre_stall", 64'(stall_count), 64'd6);
        rst = 1'b1;
        tick();
        check("rs_valid", 64'(out_valid), 64'd0);
        check("rs_ready", 64'(in_ready), 64'd1);
        check("rs_pc", 64'(out_pc), 64'd0);
        check("rs_imm", 64'(out_imm), 64'd0);
        check("rs_fmt", 64'(out_imm_fmt), 64'd0);
        check("rs_instr", 64'(out_instruction), 64'd0);
        check("rs_stall", 64'(stall_count), 64'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();

        // Saturation of the stall counter.
        in_valid = 1'b1;
        in_pc = 32'h300;
        tick();
        in_valid = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        check("sat_value", 64'(stall_count), 64'hFFFF);
        repeat (5) tick();
        check("sat_hold", 64'(stall_count), 64'hFFFF);
        check("sat_pc", 64'(out_pc), 64'h300);
        check("sat_valid", 64'(out_valid), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/immediate_decode_sequencer.md
# immediate_decode_sequencer

Decode-stage front end. Accepts fetched instructions over a valid/ready handshake, classifies each by opcode into an immediate format, extracts and sign-extends that immediate, and presents the instruction, PC, immediate and format to the execute stage through a two-entry skid buffer. It sits between the instruction-fetch and execute stages and sequences immediate decoding under backpressure and pipeline flushes.

## Interface
Parameters:
- `XLEN`, 32, datapath width (only 32 supported)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `flush`  in  1  discard all buffered entries
- `in_valid`  in  1  fetch presents an instruction
- `in_ready`  out  1  block can accept this cycle (registered)
- `in_instruction`  in  32  raw instruction
- `in_pc`  in  32  instruction address
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  execute accepts head entry
- `out_instruction`  out  32  head instruction
- `out_pc`  out  32  head PC
- `out_imm`  out  32  extended immediate
- `out_imm_fmt`  out  3  format: NONE=0, I=1, S=2, B=3, U=4, J=5
- `out_illegal`  out  1  opcode not recognised or `instruction[1:0]` != 2'b11
- `stall_count`  out  16  cycles with `out_valid & !out_ready`, saturating

## Operation
- Format map by `opcode[6:0]`:
  - I: 0000011, 0010011, 1100111, 1110011, 0001111
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - NONE, legal: 0110011
  - Anything else: NONE with `out_illegal`=1
- Immediates: I/S/B/J are sign-extended from bit 31; U = `{instr[31:12], 12'b0}`; B and J have bit 0 = 0; NONE gives 0.
- Decode is combinational on the input side. The result is captured together with the instruction and PC on acceptance.
- Acceptance (in_fire) = `in_valid & in_ready`. Release (out_fire) = `out_valid & out_ready`.
- Skid FSM, EMPTY / ONE / TWO:
  - EMPTY: in_fire -> ONE, load main.
  - ONE, in_fire & out_fire -> ONE, main <= new entry.
  - ONE, in_fire & !out_fire -> TWO, load skid.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, neither -> ONE.
  - TWO: out_fire -> ONE, main <= skid; otherwise hold.
- `in_ready` = next state != TWO, registered.
- `out_valid` = state != EMPTY. Outputs are driven from the main entry only.
- Ordering is strictly FIFO.
- `flush`: next state EMPTY and `in_ready`=1. An in_fire or out_fire in the same cycle is ignored; flush wins. Execute must not treat the flush-cycle out_fire as consumed.
- `stall_count`: +1 per cycle of `out_valid & !out_ready`, saturates at 0xFFFF, cleared only by `rst`.

## Timing
- Reset values: state EMPTY, `in_ready`=1, `out_valid`=0, all data outputs 0, `out_imm_fmt`=NONE, `out_illegal`=0, `stall_count`=0.
- Latency: in_fire in cycle N gives `out_valid` in cycle N+1 (state was EMPTY, or ONE with out_fire).
- Throughput: 1 instruction/cycle when `out_ready` is held high.
- Data outputs hold stable while `out_valid & !out_ready`.
- `in_ready` drops the cycle after the second unconsumed accept. It rises the cycle after out_fire in TWO.
- `rst` overrides everything, including mid-handshake and `flush`.

## Structure
- Shared package `decode_pkg`: `imm_fmt_e` enum (values above); opcode localparams (OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP); `dec_entry_t` struct `{instruction, pc, imm, fmt, illegal}`.
- One sub-module: `decode_skid_buffer`, a generic two-entry valid/ready buffer on `dec_entry_t` holding the FSM.
- Format classification and immediate extraction stay in the top module.

## Test plan
- Format decode, `out_ready`=1, one instruction each:
  - 0xFFF00093 -> imm 0xFFFFFFFF, fmt I
  - 0xFE112E23 -> imm 0xFFFFFFFC, fmt S
  - 0x00000863 -> imm 0x00000010, fmt B
  - 0x123452B7 -> imm 0x12345000, fmt U
  - 0xFF9FF06F -> imm 0xFFFFFFF8, fmt J
  - Each appears one cycle after accept.
- Illegal: 0x00000000 -> `out_illegal`=1, fmt NONE, imm 0. 0x002081B3 (add) -> fmt NONE, illegal 0.
- Backpressure:
  - Hold `out_ready`=0 and stream PCs 0x0, 0x4, 0x8. 0x8 is not accepted; `in_ready`=0 from the cycle after the second accept.
  - Raise `out_ready`; 0x0, 0x4, 0x8 emerge in order on consecutive cycles.
  - `stall_count` equals the stalled cycles.
- Flush: with state TWO, assert `flush` together with `in_valid` -> next cycle `out_valid`=0, `in_ready`=1, and the flush-cycle instruction never appears.
- Reset mid-stream: assert `rst` in TWO with `in_valid`=1 -> next cycle all outputs at reset values, `stall_count`=0.
- Saturation: hold `out_valid & !out_ready` for 70000 cycles -> `stall_count`=0xFFFF and holds.
